// File: rtl/keypad_matrix_emulator.sv
// 4x4 active-low matrix keypad model: presses one key with contact
// bounce on request and answers the scanner's row drive on the columns.
module keypad_matrix_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int BOUNCE_PERIOD = 2,
    parameter int HOLD_CYCLES   = 64,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_req,
    input  logic [3:0] key_code,
    output logic       key_busy,
    output logic       key_done,
    input  logic [3:0] hl,
    output logic [3:0] vl
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PB   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] LP_BNC_LAST =
        CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_PERIOD    = CNT_W'(BOUNCE_PERIOD);
    localparam logic             LP_NO_BNC    = (BOUNCE_CYCLES == 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [3:0]       r_vl;

    logic [2:0]       w_next;
    logic [CNT_W-1:0] w_quot;
    logic             w_contact;
    logic [3:0]       w_vl_next;

    // Phase sequencing: each phase lasts a fixed number of cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (key_req) w_next = LP_NO_BNC ? S_HOLD : S_PB;
            S_PB:   if (r_cnt == LP_BNC_LAST) w_next = S_HOLD;
            S_HOLD: if (r_cnt == LP_HOLD_LAST)
                        w_next = LP_NO_BNC ? S_DONE : S_RB;
            S_RB:   if (r_cnt == LP_BNC_LAST) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Contact closure: bounce toggles every BOUNCE_PERIOD cycles,
    // press bounce starts closed, release bounce starts open.
    always_comb begin
        w_quot    = r_cnt / LP_PERIOD;
        w_contact = 1'b0;
        case (r_state)
            S_PB:    w_contact = ~w_quot[0];
            S_HOLD:  w_contact = 1'b1;
            S_RB:    w_contact = w_quot[0];
            default: w_contact = 1'b0;
        endcase
        w_vl_next = 4'b1111;
        if (w_contact && !hl[r_row])
            w_vl_next = ~(4'b0001 << r_col);
    end

    // State, phase counter, latched key, and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_vl     <= 4'b1111;
            key_busy <= 1'b0;
            key_done <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || w_next == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE && key_req) begin
                r_row <= key_code[3:2];
                r_col <= key_code[1:0];
            end
            r_vl     <= w_vl_next;
            key_busy <= (w_next != S_IDLE);
            key_done <= (w_next == S_DONE);
        end
    end

    assign vl = r_vl;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: cycle model for the default build,
// vector table for a zero-bounce build.
module tb_keypad_matrix_emulator;

    localparam int B   = 8;
    localparam int P   = 2;
    localparam int H   = 64;
    localparam int TOT = 2 * B + H + 1;

    logic       clk = 1'b0;
    logic       rst, key_req, key_busy, key_done;
    logic [3:0] key_code, hl, vl;
    logic       rst2, req2, busy2, done2;
    logic [3:0] code2, hl2, vl2;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: k = 0 idle, 1..TOT = busy cycle index
    int         m_k;
    logic [1:0] m_row, m_col;
    logic [3:0] m_vl;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(B), .BOUNCE_PERIOD(P),
        .HOLD_CYCLES(H), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .key_req(key_req), .key_code(key_code),
        .key_busy(key_busy), .key_done(key_done), .hl(hl), .vl(vl)
    );

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2),
        .HOLD_CYCLES(3), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst(rst2), .key_req(req2), .key_code(code2),
        .key_busy(busy2), .key_done(done2), .hl(hl2), .vl(vl2)
    );

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] code;
        logic [3:0] hl;
        logic       busy;
        logic       done;
        logic [3:0] vl;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b",
                     nm, $time, act, exp);
        end
    endtask

    function automatic bit contact(input int k);
        if (k == 0) return 1'b0;
        if (k <= B) return ((k - 1) / P) % 2 == 0;
        if (k <= B + H) return 1'b1;
        if (k <= 2 * B + H) return ((k - B - H - 1) / P) % 2 == 1;
        return 1'b0;
    endfunction

    // apply inputs for one edge, advance model, compare at negedge
    task automatic step(input logic r, input logic q,
                        input logic [3:0] c, input logic [3:0] h);
        rst = r; key_req = q; key_code = c; hl = h;
        if (r) begin
            m_k = 0; m_row = 0; m_col = 0; m_vl = 4'b1111;
        end else begin
            m_vl = (contact(m_k) && !h[m_row]) ?
                   ~(4'b0001 << m_col) : 4'b1111;
            if (m_k == 0) begin
                if (q) begin
                    m_k = 1; m_row = c[3:2]; m_col = c[1:0];
                end
            end else if (m_k == TOT) begin
                m_k = 0;
            end else begin
                m_k++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("busy", {3'b0, key_busy}, {3'b0, m_k != 0});
        chk("done", {3'b0, key_done}, {3'b0, m_k == TOT});
        chk("vl", vl, m_vl);
    endtask

    initial begin
        int nb, nd;
        logic [3:0] rot;
        rst = 1; key_req = 0; key_code = 0; hl = 0;
        rst2 = 1; req2 = 0; code2 = 0; hl2 = 4'b1111;
        m_k = 0; m_row = 0; m_col = 0; m_vl = 4'b1111;

        // zero-bounce build: row2/col1, hl selects row2
        tbl[0] = '{1, 0, 4'b1001, 4'b1011, 0, 0, 4'b1111};
        tbl[1] = '{0, 1, 4'b1001, 4'b1011, 1, 0, 4'b1111};
        tbl[2] = '{0, 0, 4'b0000, 4'b1011, 1, 0, 4'b1101};
        tbl[3] = '{0, 0, 4'b0000, 4'b1011, 1, 0, 4'b1101};
        tbl[4] = '{0, 0, 4'b0000, 4'b1011, 1, 1, 4'b1101};
        tbl[5] = '{0, 1, 4'b0000, 4'b1011, 0, 0, 4'b1111};
        tbl[6] = '{0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111};
        tbl[7] = '{0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rst2 = tbl[i].rst; req2 = tbl[i].req;
            code2 = tbl[i].code; hl2 = tbl[i].hl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("z%0d_busy", i), {3'b0, busy2}, {3'b0, tbl[i].busy});
            chk($sformatf("z%0d_done", i), {3'b0, done2}, {3'b0, tbl[i].done});
            chk($sformatf("z%0d_vl", i), vl2, tbl[i].vl);
        end
        req2 = 0;

        // reset with all rows driven
        step(1, 0, 0, 4'b0000);
        step(1, 0, 0, 4'b0000);

        // basic press row1/col2, busy length and single done pulse
        nb = 0; nd = 0;
        step(0, 1, 4'b0110, 4'b1101);
        nb += key_busy; nd += key_done;
        for (int i = 0; i < 90; i++) begin
            step(0, 0, 4'b0000, 4'b1101);
            nb += key_busy; nd += key_done;
        end
        chk("busy_len", 4'(nb), 4'(TOT % 16));
        n_tests++;
        if (nb != TOT) begin
            n_fail++;
            $display("FAIL busy_count: got %0d expected %0d", nb, TOT);
        end
        chk("done_cnt", 4'(nd), 4'd1);

        // row scan, hl rotates every 10 cycles
        rot = 4'b1110;
        step(0, 1, 4'b1100, rot);
        for (int i = 1; i < 100; i++) begin
            if (i % 10 == 0) rot = {rot[2:0], rot[3]};
            step(0, 0, 4'b0000, rot);
        end

        // wrong row vs right row for key 0001
        step(0, 1, 4'b0001, 4'b1110);
        for (int i = 0; i < 90; i++) step(0, 0, 0, 4'b1110);
        step(0, 1, 4'b0001, 4'b1101);
        for (int i = 0; i < 90; i++) step(0, 0, 0, 4'b1101);

        // request while busy is ignored
        nd = 0;
        step(0, 1, 4'b0000, 4'b1110);
        for (int i = 0; i < 90; i++) begin
            if (i >= 40 && i < 44) step(0, 1, 4'b1111, 4'b1110);
            else step(0, 0, 4'b0000, 4'b1110);
            nd += key_done;
        end
        chk("req_busy_done", 4'(nd), 4'd1);

        // abort during hold
        nd = 0;
        step(0, 1, 4'b0101, 4'b0000);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'b0000);
        for (int i = 0; i < 90; i++) begin
            step(0, 0, 0, 4'b0000);
            nd += key_done;
        end
        chk("abort_no_done", 4'(nd), 4'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] h;
            h = ($urandom_range(0, 1) == 0) ?
                ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) == 0,
                 4'($urandom), h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
Synthesizable model of a 4x4 active-low matrix keypad: the key side of the row-scan/column-sense interface driven by the keypad scanner in the task1_2 design.
- Inputs: the scanner's row-drive lines hl.
- Outputs: the column-sense lines vl.
- On a request, it presses one key with contact bounce, holds it, releases it with bounce, then reports completion.
- Used for FPGA self-test loops and as the stimulus source in scanner benches.

Parameters:
BOUNCE_CYCLES, 8, length in clk cycles of each bounce phase, press and release; 0 = no bounce phase.
BOUNCE_PERIOD, 2, clk cycles per contact toggle during bounce; must be >= 1.
HOLD_CYCLES, 64, clk cycles of solid contact between bounce phases; must be >= 1.
CNT_W, 16, width of the internal phase counter; must hold max(BOUNCE_CYCLES, HOLD_CYCLES).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
key_req  input  1  start a press; sampled only in IDLE.
key_code  input  4  key to press, {row[1:0], col[1:0]}; latched on accept.
key_busy  output  1  high from the cycle after accept through DONE.
key_done  output  1  one-cycle pulse in the DONE state.
hl  input  4  row drive from the scanner, active low; bit r low = row r selected.
vl  output  4  column sense to the scanner, active low; 4'b1111 = no key.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, vl=4'b1111, key_busy=0, key_done=0, counters=0, latched code=0. Reset mid-press aborts immediately; no DONE pulse.
- Accept: the edge with state=IDLE and key_req=1 latches key_code into (row, col).
  - Next state is PRESS_BOUNCE, or HOLD if BOUNCE_CYCLES=0.
  - key_req is ignored in every other state; key_code changes after accept have no effect.
- States and transitions. cnt resets to 0 on every state entry and increments each cycle.
  - IDLE: contact=0.
  - PRESS_BOUNCE: BOUNCE_CYCLES cycles, then HOLD. contact=1 when (cnt / BOUNCE_PERIOD) is even, else 0. First cycle is closed.
  - HOLD: HOLD_CYCLES cycles, contact=1. Then RELEASE_BOUNCE, or DONE if BOUNCE_CYCLES=0.
  - RELEASE_BOUNCE: BOUNCE_CYCLES cycles, then DONE. contact=1 when (cnt / BOUNCE_PERIOD) is odd, else 0. First cycle is open.
  - DONE: 1 cycle, contact=0, key_done=1; then IDLE.
- key_busy = 1 in every state except IDLE. Busy duration = 2*BOUNCE_CYCLES + HOLD_CYCLES + 1 cycles.
- Column output is registered, one cycle after hl/contact:
  - vl <= (contact && hl[row]==0) ? ~(4'b0001 << col) : 4'b1111.
  - Only bit col can ever go low.
  - Other hl bits are don't-care: several rows low at once (illegal scan) still responds if hl[row] is low.
- hl is used as-is, without synchronization; it is assumed to come from the same clock domain.
- In IDLE and DONE, vl=4'b1111 regardless of hl, from the following cycle onward.
- key_done and key_busy are registered state decodes and are glitch-free.

Test Plan:
1. Reset: rst=1 for 2 cycles with hl=4'b0000 -> vl=4'b1111, key_busy=0, key_done=0.
2. Basic press, defaults: key_code=4'b0110 (row1, col2) with hl held at 4'b1101. Required response:
   - key_busy high for exactly 81 cycles.
   - During HOLD, vl=4'b1011.
   - In bounce phases vl alternates between 4'b1011 and 4'b1111 every 2 cycles: press starts low, release starts high.
   - key_done pulses once, in the last busy cycle.
3. Row scan: key_code=4'b1100 (row3, col0) while hl rotates 1110, 1101, 1011, 0111 every 100 ns. In HOLD, vl=4'b1110 exactly in the cycle after hl=4'b0111; otherwise vl=4'b1111.
4. Wrong row: key_code=4'b0001 with hl fixed at 4'b1110 (row0 driven) -> vl toggles bit1 low; with hl fixed at 4'b1101 -> vl stays 4'b1111 for the whole press.
5. Request while busy: key_req re-asserted with key_code=4'b1111 mid-HOLD -> ignored; the original code stays active and exactly one key_done pulse occurs.
6. Abort and zero bounce: rst asserted during HOLD -> vl=4'b1111 and key_busy=0 on the next cycle, with no key_done. With BOUNCE_CYCLES=0, HOLD_CYCLES=3 -> busy for 4 cycles and solid contact with no toggling.
